// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one Y86 ALU (addq/subq/andq/xorq) between two requesters.
// Each operation takes IDLE -> EXEC -> RESP and updates the result and condition codes.
module alu_share_arbiter #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [3:0]       ifun0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             req1,
  input  logic [3:0]       ifun1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] result,
  output logic             zf,
  output logic             sf,
  output logic             of,
  output logic             err
);

  localparam int MSB = WIDTH - 1;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state, state_next;
  logic             owner, last_grant;
  logic [3:0]       op_ifun;
  logic [WIDTH-1:0] op_a, op_b;
  logic             take, pick;
  logic [WIDTH-1:0] alu_r;
  logic             alu_of, alu_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // On a tie the requester that was not served last wins.
  always_comb begin
    state_next = state;
    take       = 1'b0;
    pick       = 1'b0;
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    done0      = 1'b0;
    done1      = 1'b0;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          take       = 1'b1;
          state_next = EXEC;
          pick       = (req0 && req1) ? ~last_grant : req1;
        end
      end
      EXEC: begin
        gnt0       = ~owner;
        gnt1       = owner;
        state_next = RESP;
      end
      RESP: begin
        done0      = ~owner;
        done1      = owner;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner      <= 1'b0;
      last_grant <= 1'b1;
      op_ifun    <= '0;
      op_a       <= '0;
      op_b       <= '0;
    end else begin
      if (take) begin
        owner   <= pick;
        op_ifun <= pick ? ifun1 : ifun0;
        op_a    <= pick ? a1 : a0;
        op_b    <= pick ? b1 : b0;
      end
      if (state == RESP) last_grant <= owner;
    end
  end

  // Y86 operand order: the result is valB op valA.
  always_comb begin
    alu_r     = '0;
    alu_of    = 1'b0;
    alu_valid = 1'b1;
    case (op_ifun)
      4'd0: begin
        alu_r  = op_b + op_a;
        alu_of = (op_a[MSB] == op_b[MSB]) && (alu_r[MSB] != op_a[MSB]);
      end
      4'd1: begin
        alu_r  = op_b - op_a;
        alu_of = (op_a[MSB] != op_b[MSB]) && (alu_r[MSB] != op_b[MSB]);
      end
      4'd2:    alu_r = op_b & op_a;
      4'd3:    alu_r = op_b ^ op_a;
      default: alu_valid = 1'b0;
    endcase
  end

  // An invalid function clears the result but leaves the condition codes alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result <= '0;
      zf     <= 1'b1;
      sf     <= 1'b0;
      of     <= 1'b0;
      err    <= 1'b0;
    end else if (state == EXEC) begin
      if (alu_valid) begin
        result <= alu_r;
        zf     <= (alu_r == '0);
        sf     <= alu_r[MSB];
        of     <= alu_of;
        err    <= 1'b0;
      end else begin
        result <= '0;
        err    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: vector table for single operations plus
// hand-written round-robin and reset-during-EXEC sequences.
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1;
  logic [3:0]  ifun0, ifun1;
  logic [63:0] a0, b0, a1, b1;
  logic        gnt0, gnt1, done0, done1;
  logic [63:0] result;
  logic        zf, sf, of, err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        who;
    logic [3:0]  ifun;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] res;
    logic        zf;
    logic        sf;
    logic        of;
    logic        err;
  } vec_t;

  vec_t vecs[10];

  alu_share_arbiter #(.WIDTH(64)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .ifun0(ifun0), .a0(a0), .b0(b0),
    .req1(req1), .ifun1(ifun1), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .result(result), .zf(zf), .sf(sf), .of(of), .err(err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  // Issues one request, checks the grant at T+1 and the done/result at T+2.
  task automatic applyStimulus(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("v%0d", idx);
    @(negedge clk);
    req0 = ~v.who; req1 = v.who;
    ifun0 = v.ifun; a0 = v.a; b0 = v.b;
    ifun1 = v.ifun; a1 = v.a; b1 = v.b;
    @(posedge clk);
    @(negedge clk);
    checkOutput({tag, "_gnt_own"}, v.who ? gnt1 : gnt0, 1);
    checkOutput({tag, "_gnt_other"}, v.who ? gnt0 : gnt1, 0);
    req0 = 1'b0; req1 = 1'b0;
    a0 = 64'hDEAD_BEEF; b0 = 64'h1234; a1 = 64'hDEAD_BEEF; b1 = 64'h1234;
    @(negedge clk);
    checkOutput({tag, "_done_own"}, v.who ? done1 : done0, 1);
    checkOutput({tag, "_done_other"}, v.who ? done0 : done1, 0);
    checkOutput({tag, "_result"}, result, v.res);
    checkOutput({tag, "_zf"}, zf, v.zf);
    checkOutput({tag, "_sf"}, sf, v.sf);
    checkOutput({tag, "_of"}, of, v.of);
    checkOutput({tag, "_err"}, err, v.err);
  endtask

  initial begin
    int order[$];
    int dcount;

    vecs[0] = '{1'b0, 4'd2, 64'hB, 64'h4, 64'h0, 1, 0, 0, 0};
    vecs[1] = '{1'b1, 4'd1, 64'd2, 64'd17, 64'd15, 0, 0, 0, 0};
    vecs[2] = '{1'b1, 4'd1, 64'd17, 64'd2, 64'hFFFF_FFFF_FFFF_FFF1, 0, 1, 0, 0};
    vecs[3] = '{1'b0, 4'd0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 0, 1, 1, 0};
    vecs[4] = '{1'b0, 4'd5, 64'd3, 64'd4, 64'h0, 0, 1, 1, 1};
    vecs[5] = '{1'b0, 4'd3, 64'h9, 64'h9, 64'h0, 1, 0, 0, 0};
    vecs[6] = '{1'b1, 4'd1, 64'd1, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 0, 0, 1, 0};
    vecs[7] = '{1'b1, 4'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1, 0, 0, 0};
    vecs[8] = '{1'b1, 4'd2, 64'hF0F0, 64'hFF00, 64'hF000, 0, 0, 0, 0};
    vecs[9] = '{1'b0, 4'd0, 64'd5, 64'd6, 64'd11, 0, 0, 0, 0};

    reset = 1'b1;
    req0 = 0; req1 = 0; ifun0 = 0; ifun1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
    repeat (2) @(negedge clk);
    checkOutput("rst_gnt", {gnt0, gnt1}, 0);
    checkOutput("rst_done", {done0, done1}, 0);
    checkOutput("rst_result", result, 0);
    checkOutput("rst_flags", {zf, sf, of, err}, 4'b1000);
    reset = 1'b0;

    // Table vectors 0..8; vector 9 is used later to set last_grant to 0.
    for (int i = 0; i < 9; i++) applyStimulus(i, vecs[i]);

    // Both held high: alternating grants, one done every 3 cycles.
    @(negedge clk);
    req0 = 1; ifun0 = 0; a0 = 1; b0 = 1;
    req1 = 1; ifun1 = 0; a1 = 2; b1 = 2;
    dcount = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      checkOutput("rr_not_both_gnt", gnt0 & gnt1, 0);
      checkOutput("rr_not_both_done", done0 & done1, 0);
      checkOutput("rr_gnt_timing", gnt0 | gnt1, (i % 3) == 1);
      checkOutput("rr_done_timing", done0 | done1, (i % 3) == 2);
      if (gnt0) order.push_back(0);
      if (gnt1) order.push_back(1);
      if (done0) begin dcount++; checkOutput("rr_result0", result, 2); end
      if (done1) begin dcount++; checkOutput("rr_result1", result, 4); end
    end
    req0 = 0; req1 = 0;
    checkOutput("rr_grant_count", order.size(), 4);
    checkOutput("rr_done_count", dcount, 4);
    for (int k = 0; k < order.size() && k < 4; k++)
      checkOutput($sformatf("rr_order%0d", k), order[k], k % 2);

    applyStimulus(9, vecs[9]);

    // Reset during requester 1's EXEC cycle.
    @(negedge clk);
    req1 = 1; ifun1 = 0; a1 = 3; b1 = 4;
    @(posedge clk);
    @(negedge clk);
    checkOutput("mid_gnt1_before", gnt1, 1);
    req1 = 0;
    #1 reset = 1'b1;
    #1;
    checkOutput("mid_gnt1_after", gnt1, 0);
    checkOutput("mid_done", {done0, done1}, 0);
    checkOutput("mid_result", result, 0);
    checkOutput("mid_flags", {zf, sf, of, err}, 4'b1000);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("mid_no_done1", done1, 0);
    end
    req0 = 1; ifun0 = 0; a0 = 1; b0 = 1;
    req1 = 1; ifun1 = 0; a1 = 2; b1 = 2;
    @(posedge clk);
    @(negedge clk);
    checkOutput("post_rst_gnt", {gnt0, gnt1}, 2'b10);
    req0 = 0; req1 = 0;
    @(negedge clk);
    checkOutput("post_rst_done0", done0, 1);
    checkOutput("post_rst_result", result, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
